// File: rtl/mux_sweep_checker.sv
// Response checker for exhaustive multiplexer sweeps: accepts one (data, sel) vector per
// handshake, waits SETTLE cycles, then scores the mux-under-test output against data[sel].
module mux_sweep_checker #(
  parameter int N_SEL   = 3,
  parameter int SETTLE  = 4,
  parameter int NUM_VEC = 2048,
  parameter int ERR_W   = 16,
  parameter int VEC_W   = 16,
  localparam int DW     = 2 ** N_SEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_vld,
  output logic             sample_rdy,
  input  logic [DW-1:0]    data_in,
  input  logic [N_SEL-1:0] sel_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [VEC_W-1:0] vec_cnt,
  output logic             ff_vld,
  output logic [DW-1:0]    ff_data,
  output logic [N_SEL-1:0] ff_sel,
  output logic             ff_got
);

  localparam int               CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VEC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  settle_cnt;
  logic [DW-1:0]     lat_data;
  logic [N_SEL-1:0]  lat_sel;
  logic [VEC_W-1:0]  vec_nxt;
  logic              accept;
  logic              clear;
  logic              expected;
  logic              mismatch;

  assign accept   = sample_rdy & sample_vld;
  assign clear    = start & ((state == S_IDLE) | (state == S_DONE));
  assign vec_nxt  = vec_cnt + 1'b1;
  assign expected = lat_data[lat_sel];
  // Case inequality so an X/Z on the mux output is scored as a failure in simulation.
  assign mismatch = (dut_out !== expected);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    sample_rdy = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        sample_rdy = 1'b1;
        busy       = 1'b1;
        if (sample_vld) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == '0) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        busy      = 1'b1;
        state_nxt = (vec_nxt == LAST_VEC) ? S_DONE : S_ARMED;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_ARMED;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign pass = done & (err_cnt == '0);

  // NOTE: the latched vector is reset as well, so nothing reads X straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_data   <= '0;
      lat_sel    <= '0;
      settle_cnt <= '0;
    end else if (accept) begin
      lat_data   <= data_in;
      lat_sel    <= sel_in;
      settle_cnt <= SETTLE_LOAD;
    end else if (state == S_SETTLE && settle_cnt != '0) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  // Statistics move only on a (re)start or in CHECK; the first failure is captured once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      vec_cnt <= '0;
      ff_vld  <= 1'b0;
      ff_data <= '0;
      ff_sel  <= '0;
      ff_got  <= 1'b0;
    end else if (clear) begin
      err_cnt <= '0;
      vec_cnt <= '0;
      ff_vld  <= 1'b0;
      ff_data <= '0;
      ff_sel  <= '0;
      ff_got  <= 1'b0;
    end else if (state == S_CHECK) begin
      vec_cnt <= vec_nxt;
      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        if (!ff_vld) begin
          ff_vld  <= 1'b1;
          ff_data <= lat_data;
          ff_sel  <= lat_sel;
          ff_got  <= dut_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_sweep_checker.sv
// Self-checking bench for mux_sweep_checker: sweeps and random runs against a simple
// mux-under-test harness, scored by a vector-level reference model.
module tb_mux_sweep_checker;

  localparam int SETTLE  = 4;
  localparam int NUM_VEC = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sample_vld = 1'b0;
  logic [7:0]  data_in = '0;
  logic [2:0]  sel_in = '0;
  logic        dut_out;

  logic        sample_rdy, busy, done, pass, ff_vld, ff_got;
  logic [15:0] err_cnt, vec_cnt;
  logic [7:0]  ff_data;
  logic [2:0]  ff_sel;

  logic        e4_rdy, e4_busy, e4_done, e4_pass, e4_ff_vld, e4_ff_got;
  logic [3:0]  e4_err_cnt;
  logic [15:0] e4_vec_cnt;
  logic [7:0]  e4_ff_data;
  logic [2:0]  e4_ff_sel;

  mux_sweep_checker dut (
    .clk(clk), .rst(rst), .start(start), .sample_vld(sample_vld), .sample_rdy(sample_rdy),
    .data_in(data_in), .sel_in(sel_in), .dut_out(dut_out), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .vec_cnt(vec_cnt), .ff_vld(ff_vld), .ff_data(ff_data),
    .ff_sel(ff_sel), .ff_got(ff_got)
  );

  mux_sweep_checker #(.ERR_W(4)) dut_e4 (
    .clk(clk), .rst(rst), .start(start), .sample_vld(sample_vld), .sample_rdy(e4_rdy),
    .data_in(data_in), .sel_in(sel_in), .dut_out(dut_out), .busy(e4_busy), .done(e4_done),
    .pass(e4_pass), .err_cnt(e4_err_cnt), .vec_cnt(e4_vec_cnt), .ff_vld(e4_ff_vld),
    .ff_data(e4_ff_data), .ff_sel(e4_ff_sel), .ff_got(e4_ff_got)
  );

  always #5 clk = ~clk;

  // Mux under test: its inputs load on each handshake; mode selects ideal / stuck-at-0 /
  // output delayed by dly_idx+1 cycles / ideal with a per-vector injected flip.
  int          mode = 0;
  logic [2:0]  dly_idx = 3'd0;
  logic [7:0]  mux_data = '0;
  logic [2:0]  mux_sel = '0;
  logic        flip_nxt = 1'b0;
  logic        flip_r = 1'b0;
  logic [7:0]  hist = '0;
  int          cyc = 0;
  int          xfer_cyc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    hist <= {hist[6:0], mux_data[mux_sel]};
    if (sample_vld && sample_rdy) begin
      mux_data <= data_in;
      mux_sel  <= sel_in;
      flip_r   <= flip_nxt;
      xfer_cyc.push_back(cyc);
    end
  end

  always_comb begin
    dut_out = mux_data[mux_sel];
    case (mode)
      1: dut_out = 1'b0;
      2: dut_out = hist[dly_idx];
      3: dut_out = mux_data[mux_sel] ^ flip_r;
      default: dut_out = mux_data[mux_sel];
    endcase
  end

  int   n_cmp = 0;
  int   n_fail = 0;
  logic cur_ideal = 1'b0;
  logic prev_ideal = 1'b0;

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one vector and returns at the negedge after it was accepted (bounded wait).
  task automatic send(input logic [7:0] d, input logic [2:0] s, input logic f, output bit ok);
    int n = 0;
    data_in = d; sel_in = s; flip_nxt = f; sample_vld = 1'b1;
    while (sample_rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (sample_rdy === 1'b1);
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
      prev_ideal = cur_ideal;
      cur_ideal  = d[s];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sample_rdy, busy, done, pass, err_cnt, vec_cnt, ff_vld, ff_data, ff_sel, ff_got} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b busy=%b done=%b pass=%b err=%0d vec=%0d ffv=%b required all 0",
               sample_rdy, busy, done, pass, err_cnt, vec_cnt, ff_vld);
    end
    rst = 1'b0;
    sample_vld = 1'b1;
    repeat (3) @(negedge clk);
    sample_vld = 1'b0;
    n_cmp++;
    if (sample_rdy !== 1'b0 || busy !== 1'b0 || xfer_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL idle_after_reset: rdy=%b busy=%b xfers=%0d required 0 0 0", sample_rdy, busy, xfer_cyc.size());
    end
  endtask

  // Exhaustive sweep (data outer, sel inner) with vld held high throughout.
  // The mux output at the sample edge reflects the current vector when the delay is at
  // most SETTLE cycles, else the previous one.
  task automatic test_sweep(input int m, input int k, input string name);
    bit ok;
    int err = 0, to = 0, base, iv_min = 1 << 30, iv_max = 0;
    logic eb, gb, fv = 1'b0, fg = 1'b0;
    logic [7:0] d, fd = '0;
    logic [2:0] s, fs = '0;
    logic [15:0] exp_err;
    logic [3:0]  exp_e4;
    mode = m;
    dly_idx = (k > 0) ? 3'(k - 1) : 3'd0;
    pulse_start();
    base = xfer_cyc.size();
    for (int di = 0; di < 256; di++) begin
      for (int si = 0; si < 8; si++) begin
        d = 8'(di); s = 3'(si); eb = d[s];
        send(d, s, 1'b0, ok);
        if (!ok) begin
          n_cmp++; n_fail++;
          $display("FAIL %s handshake: no sample_rdy within 50 cycles at vector %0d", name, di * 8 + si);
          sample_vld = 1'b0;
          return;
        end
        case (m)
          0: gb = eb;
          1: gb = 1'b0;
          default: gb = (k <= SETTLE) ? cur_ideal : prev_ideal;
        endcase
        if (gb !== eb) begin
          err++;
          if (!fv) begin fv = 1'b1; fd = d; fs = s; fg = gb; end
        end
      end
    end
    sample_vld = 1'b0;
    while (done !== 1'b1 && to < 100) begin
      @(negedge clk);
      to++;
    end
    for (int i = base + 1; i < xfer_cyc.size(); i++) begin
      if (xfer_cyc[i] - xfer_cyc[i-1] < iv_min) iv_min = xfer_cyc[i] - xfer_cyc[i-1];
      if (xfer_cyc[i] - xfer_cyc[i-1] > iv_max) iv_max = xfer_cyc[i] - xfer_cyc[i-1];
    end
    exp_err = (err > 65535) ? 16'hFFFF : 16'(err);
    exp_e4  = (err > 15) ? 4'hF : 4'(err);
    n_cmp++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL %s done: got %b want 1", name, done); end
    n_cmp++;
    if (vec_cnt !== 16'd2048) begin n_fail++; $display("FAIL %s vec_cnt: got %0d want 2048", name, vec_cnt); end
    n_cmp++;
    if (err_cnt !== exp_err) begin n_fail++; $display("FAIL %s err_cnt: got %0d want %0d", name, err_cnt, exp_err); end
    n_cmp++;
    if (pass !== (err == 0)) begin n_fail++; $display("FAIL %s pass: got %b want %b", name, pass, err == 0); end
    n_cmp++;
    if ({ff_vld, ff_data, ff_sel, ff_got} !== {fv, fd, fs, fg}) begin
      n_fail++;
      $display("FAIL %s first_fail: got vld=%b data=%h sel=%0d got=%b want vld=%b data=%h sel=%0d got=%b",
               name, ff_vld, ff_data, ff_sel, ff_got, fv, fd, fs, fg);
    end
    n_cmp++;
    if (e4_err_cnt !== exp_e4 || e4_vec_cnt !== 16'd2048 || e4_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s narrow_err: got err=%0d vec=%0d done=%b want err=%0d vec=2048 done=1",
               name, e4_err_cnt, e4_vec_cnt, e4_done, exp_e4);
    end
    n_cmp++;
    if (iv_min != SETTLE + 2 || iv_max != SETTLE + 2) begin
      n_fail++;
      $display("FAIL %s accept_interval: got min=%0d max=%0d want %0d", name, iv_min, iv_max, SETTLE + 2);
    end
  endtask

  task automatic test_delay();
    test_sweep(2, SETTLE + 1, "delay_settle_p1");
    n_cmp++;
    if (err_cnt == 16'd0 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL delay_late_detected: got err=%0d pass=%b want err>0 pass=0", err_cnt, pass);
    end
    test_sweep(2, SETTLE - 1, "delay_settle_m1");
  endtask

  task automatic test_done_restart();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || vec_cnt !== 16'd2048 || err_cnt == 16'd0) begin
      n_fail++;
      $display("FAIL done_hold: got done=%b vec=%0d err=%0d want 1, 2048, nonzero", done, vec_cnt, err_cnt);
    end
    pulse_start();
    n_cmp++;
    if ({done, pass, err_cnt, vec_cnt, ff_vld, ff_data, ff_sel, ff_got} !== '0 || busy !== 1'b1 || sample_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_from_done: got done=%b err=%0d vec=%0d ffv=%b busy=%b rdy=%b want 0 0 0 0 1 1",
               done, err_cnt, vec_cnt, ff_vld, busy, sample_rdy);
    end
  endtask

  // Random vectors, random idle gaps and injected flips; start pulses mid-run are ignored.
  task automatic test_random();
    bit ok;
    int err = 0, to = 0;
    logic eb, f, fv = 1'b0, fg = 1'b0;
    logic [7:0] d, fd = '0;
    logic [2:0] s, fs = '0;
    logic [3:0] exp_e4;
    mode = 3;
    pulse_start();
    for (int i = 0; i < NUM_VEC; i++) begin
      int gap = $urandom_range(0, 2);
      if (gap > 0) begin
        sample_vld = 1'b0;
        repeat (gap) @(negedge clk);
      end
      d = 8'($urandom); s = 3'($urandom); f = ($urandom_range(0, 3) == 0);
      eb = d[s];
      send(d, s, f, ok);
      if (!ok) begin
        n_cmp++; n_fail++;
        $display("FAIL random handshake: no sample_rdy within 50 cycles at vector %0d", i);
        sample_vld = 1'b0;
        return;
      end
      if (f) begin
        err++;
        if (!fv) begin fv = 1'b1; fd = d; fs = s; fg = ~eb; end
      end
      if (i == 700 || i == 1400) pulse_start();
    end
    sample_vld = 1'b0;
    while (done !== 1'b1 && to < 100) begin
      @(negedge clk);
      to++;
    end
    exp_e4 = (err > 15) ? 4'hF : 4'(err);
    n_cmp++;
    if (done !== 1'b1 || vec_cnt !== 16'd2048) begin
      n_fail++;
      $display("FAIL random_complete: got done=%b vec=%0d want 1 2048", done, vec_cnt);
    end
    n_cmp++;
    if (err_cnt !== 16'(err) || pass !== (err == 0)) begin
      n_fail++;
      $display("FAIL random_err_cnt: got err=%0d pass=%b want err=%0d pass=%b", err_cnt, pass, err, err == 0);
    end
    n_cmp++;
    if ({ff_vld, ff_data, ff_sel, ff_got} !== {fv, fd, fs, fg}) begin
      n_fail++;
      $display("FAIL random_first_fail: got vld=%b data=%h sel=%0d got=%b want vld=%b data=%h sel=%0d got=%b",
               ff_vld, ff_data, ff_sel, ff_got, fv, fd, fs, fg);
    end
    n_cmp++;
    if (e4_err_cnt !== exp_e4) begin
      n_fail++;
      $display("FAIL random_narrow_err: got %0d want %0d", e4_err_cnt, exp_e4);
    end
  endtask

  // Sample/update latency, back-to-back throughput and an asynchronous abort mid-SETTLE.
  task automatic test_timing_rst();
    bit ok;
    int base, n0, bad = 0;
    mode = 1;
    pulse_start();
    send(8'hFF, 3'd0, 1'b0, ok);
    n_cmp++;
    if (!ok || sample_rdy !== 1'b0 || busy !== 1'b1 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL settle_entry: ok=%b rdy=%b busy=%b pass=%b want 1 0 1 0", ok, sample_rdy, busy, pass);
    end
    base = xfer_cyc.size() - 1;
    repeat (SETTLE) @(negedge clk);
    n_cmp++;
    if (vec_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL early_update: got vec=%0d err=%0d before sample edge, want 0 0", vec_cnt, err_cnt);
    end
    @(negedge clk);
    n_cmp++;
    if (vec_cnt !== 16'd1 || err_cnt !== 16'd1 || sample_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL sample_update: got vec=%0d err=%0d rdy=%b want 1 1 1", vec_cnt, err_cnt, sample_rdy);
    end
    for (int i = 0; i < 10; i++) begin
      send(8'hFF, 3'($urandom), 1'b0, ok);
      if (!ok) bad++;
    end
    for (int i = base + 1; i < xfer_cyc.size(); i++)
      if (xfer_cyc[i] - xfer_cyc[i-1] != SETTLE + 2) bad++;
    n_cmp++;
    if (bad != 0 || xfer_cyc.size() - base != 11) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d bad intervals over %0d accepts, want 0 over 11", bad, xfer_cyc.size() - base);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({sample_rdy, busy, done, pass, err_cnt, vec_cnt, ff_vld, ff_data, ff_sel, ff_got} !== '0 ||
        e4_err_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL async_rst: got rdy=%b busy=%b err=%0d vec=%0d ffv=%b ffd=%h want all 0",
               sample_rdy, busy, err_cnt, vec_cnt, ff_vld, ff_data);
    end
    @(negedge clk);
    rst = 1'b0;
    n0 = xfer_cyc.size();
    data_in = 8'hA5; sample_vld = 1'b1;
    repeat (20) @(negedge clk);
    sample_vld = 1'b0;
    n_cmp++;
    if (xfer_cyc.size() != n0 || busy !== 1'b0 || vec_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL idle_after_abort: got %0d accepts busy=%b vec=%0d want 0 0 0", xfer_cyc.size() - n0, busy, vec_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_sweep(0, 0, "ideal_sweep");
    test_sweep(1, 0, "stuck0_sweep");
    test_done_restart();
    test_delay();
    test_random();
    test_timing_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
